fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction fetch stage for the LEGv8 core. It replaces the directly driven instruction wire with a real fetch path.
- Owns the PC, issues sequential read requests to instruction memory over a valid/ready handshake, and buffers in-order responses in a DEPTH-entry queue.
- Presents instruction plus PC to the Controller with valid/ready.
- Supports branch redirect: flushes the queue and discards stale in-flight responses.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- INSTR_WIDTH, 32, instruction word width.
- DEPTH, 4, instruction queue entries; power of two, >=2.
- MAX_OUTSTANDING, 4, maximum un-responded memory requests; >=1.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  branch taken; load redirect_pc this cycle.
- redirect_pc  in  ADDR_WIDTH  branch target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_WIDTH  fetch address.
- imem_resp_valid  in  1  response word valid; responses return in request order.
- imem_resp_data  in  INSTR_WIDTH  fetched instruction.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  Controller consumes head.
- instr_data  out  INSTR_WIDTH  head instruction.
- instr_pc  out  ADDR_WIDTH  PC of head instruction.

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, resp_pc=RESET_PC; queue empty; outstanding=0, drop_count=0; imem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0.
- Issue rule: imem_req_valid=1 when (queue_count + outstanding) < DEPTH, outstanding < MAX_OUTSTANDING, and not in reset. imem_req_addr=fetch_pc.
  - On accept (valid&ready): fetch_pc += PC_STEP (modulo 2^ADDR_WIDTH; wraps at max), outstanding++.
  - This credit rule guarantees a queue slot for every accepted response, so responses are never back-pressured.
- Response rule: on imem_resp_valid, outstanding--.
  - If drop_count>0: discard the word, drop_count--.
  - Else: push {resp_pc, data}, resp_pc += PC_STEP.
  - A pushed entry is visible on instr_valid the next cycle; there is no empty-queue bypass, so minimum latency is request accept -> response cycle -> +1 cycle.
- Consume: instr_valid&instr_ready pops the head. Push and pop in the same cycle leave the count unchanged. Full and pop-only behave normally.
- Redirect (redirect_valid=1):
  - Next state: fetch_pc=redirect_pc, resp_pc=redirect_pc, queue emptied.
  - drop_count = outstanding after this cycle's accept/response updates. A request accepted this cycle counts as stale; a response arriving this cycle is discarded.
  - A consume handshake in the same cycle completes; that instruction belongs to the consumer and all other entries are flushed.
  - Redirect while a request is unaccepted: the address may change next cycle; this is the only case where an unaccepted request's address changes.
  - Back-to-back redirects: the last one wins; drop_count accumulates outstanding correctly.
- An imem_resp_valid with outstanding==0 is a protocol error; it is ignored and the counters are not changed.
- Assertion of reset mid-transfer: all state is cleared. Memory responses arriving after reset deasserts for pre-reset requests are the memory's responsibility; the memory is reset together with this block.

Optional Feature:
- FETCH_PERF_EN
  - Defined: adds outputs perf_fetched (32b, pushed instructions), perf_dropped (32b, discarded responses), perf_stall (32b, cycles with instr_ready=1 and instr_valid=0).
    - All three reset to 0 and wrap modulo 2^32.
  - Undefined: these ports and counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- Streaming: reset, memory ready=1, 1-cycle response latency, instr_ready=1 -> instr_pc sequence 0,4,8,12,16 on consecutive cycles after the first arrival; instr_data matches memory words, e.g. 0x8B150289 at 0.
- Back-pressure: instr_ready=0 -> exactly DEPTH=4 requests issued, then imem_req_valid=0. Release instr_ready -> fetching resumes at 0x10; no entry lost or duplicated.
- Redirect with 2 outstanding: redirect_valid, redirect_pc=0x100 -> next 2 responses dropped; the first instruction delivered has instr_pc=0x100; no old-PC entry appears after the redirect cycle.
- Simultaneous: redirect plus response plus request accept plus consume in one cycle -> consumed instruction counted once; the response dropped; drop_count covers the new request; next delivered instr_pc=redirect_pc.
- Async reset mid-stream with the queue holding 3 entries -> instr_valid and imem_req_valid fall without a clock edge; after release, the first request address is RESET_PC.
- PC wrap (ADDR_WIDTH=8, RESET_PC=0xF8) -> instr_pc sequence 0xF8, 0xFC, 0x00, 0x04. With FETCH_PERF_EN defined, perf_fetched=4.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage for the LEGv8 core. Owns the PC,
//                issues sequential read requests to instruction memory over a
//                valid/ready handshake, buffers in-order responses in a
//                DEPTH-entry queue and presents instruction + PC to the
//                Controller with valid/ready. A branch redirect flushes the
//                queue and discards responses of stale in-flight requests.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock            in   rising-edge clock
//    reset            in   asynchronous, active-high reset
//    redirect_valid   in   branch taken, load redirect_pc this cycle
//    redirect_pc      in   branch target address
//    imem_req_valid   out  fetch request valid
//    imem_req_ready   in   memory accepts request
//    imem_req_addr    out  fetch address
//    imem_resp_valid  in   response word valid (in request order)
//    imem_resp_data   in   fetched instruction word
//    instr_valid      out  queue head valid
//    instr_ready      in   Controller consumes head
//    instr_data       out  head instruction (0 when queue empty)
//    instr_pc         out  PC of head instruction (0 when queue empty)
//    perf_fetched     out  [FETCH_PERF_EN] pushed instruction count
//    perf_dropped     out  [FETCH_PERF_EN] discarded response count
//    perf_stall       out  [FETCH_PERF_EN] cycles consumer waited on empty queue
//
//  Build option
//    FETCH_PERF_EN    when defined, adds the three 32-bit wrapping performance
//                     counters above; core behaviour is identical either way.
// ============================================================================
module fetch_unit #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    INSTR_WIDTH     = 32,
    parameter int                    DEPTH           = 4,
    parameter int                    MAX_OUTSTANDING = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
    parameter int                    PC_STEP         = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
`ifdef FETCH_PERF_EN
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_dropped,
    output logic [31:0]            perf_stall,
`endif
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_pc
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_out_w = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_sum_w = $clog2(DEPTH + MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] c_step = ADDR_WIDTH'(PC_STEP);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]  r_fetch_pc;   // address of next request
    logic [ADDR_WIDTH-1:0]  r_resp_pc;    // PC tagged onto next kept response
    logic [c_out_w-1:0]     r_out;        // accepted, not yet responded
    logic [c_out_w-1:0]     r_drop;       // stale responses still to discard
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_cnt_w-1:0]     r_count;

    logic [INSTR_WIDTH-1:0] r_q_data [DEPTH];
    logic [ADDR_WIDTH-1:0]  r_q_pc   [DEPTH];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic                   w_q_empty;
    logic                   w_credit_ok;
    logic                   w_out_ok;
    logic                   w_req_valid;
    logic                   w_req_fire;
    logic                   w_resp_fire;
    logic                   w_resp_drop;
    logic                   w_push;
    logic                   w_pop;
    logic [c_out_w-1:0]     w_out_next;

    assign w_q_empty = (r_count == '0);

    // Every accepted request reserves a queue slot up front, so a response
    // always finds room and the memory never has to be back-pressured.
    assign w_credit_ok = (c_sum_w'(r_count) + c_sum_w'(r_out)) < c_sum_w'(DEPTH);
    assign w_out_ok    = (r_out < c_out_w'(MAX_OUTSTANDING));
    assign w_req_valid = !reset && w_credit_ok && w_out_ok;
    assign w_req_fire  = w_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp_fire = imem_resp_valid && (r_out != '0);
    assign w_resp_drop = w_resp_fire && (r_drop != '0);

    // A response landing in a redirect cycle belongs to the old path.
    assign w_push = w_resp_fire && (r_drop == '0) && !redirect_valid;
    assign w_pop  = !w_q_empty && instr_ready;

    assign w_out_next = r_out + c_out_w'(w_req_fire) - c_out_w'(w_resp_fire);

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out      <= '0;
            r_drop     <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_out <= w_out_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle, including a
                // request accepted right now, fetched the wrong path.
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
                r_drop     <= w_out_next;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + c_step;
                end
                if (w_resp_drop) begin
                    r_drop <= r_drop - c_out_w'(1);
                end
                if (w_push) begin
                    r_wr_ptr  <= r_wr_ptr + c_ptr_w'(1);
                    r_resp_pc <= r_resp_pc + c_step;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_cnt_w'(1);
                    2'b01:   r_count <= r_count - c_cnt_w'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage needs no reset: contents are only visible while counted.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= imem_resp_data;
            r_q_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign instr_valid    = !w_q_empty;
    assign instr_data     = w_q_empty ? '0 : r_q_data[r_rd_ptr];
    assign instr_pc       = w_q_empty ? '0 : r_q_pc[r_rd_ptr];

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_push) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            // Any accepted response that is not queued was discarded.
            if (w_resp_fire && !w_push) begin
                r_perf_dropped <= r_perf_dropped + 32'd1;
            end
            if (instr_ready && w_q_empty) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A transaction-level
//                model (queues of expected entries and pending memory
//                requests) predicts the outputs every cycle; directed phases
//                add literal expectations. A second instance with an 8-bit
//                address checks PC wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // Main instance (default parameters)
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_dropped, perf_stall;
    logic [31:0] perf_fetched2, perf_dropped2, perf_stall2;
`endif

    fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
`ifdef FETCH_PERF_EN
        .perf_fetched    (perf_fetched),
        .perf_dropped    (perf_dropped),
        .perf_stall      (perf_stall),
`endif
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc)
    );

    // Wrap instance: 8-bit address starting near the top of the space
    logic        reset2;
    logic        req_valid2;
    logic        req_ready2;
    logic [7:0]  req_addr2;
    logic        resp_valid2;
    logic [31:0] resp_data2;
    logic        ivalid2;
    logic        iready2;
    logic [31:0] idata2;
    logic [7:0]  ipc2;

    fetch_unit #(
        .ADDR_WIDTH (8),
        .RESET_PC   (8'hF8)
    ) dut_wrap (
        .clock           (clock),
        .reset           (reset2),
        .redirect_valid  (1'b0),
        .redirect_pc     (8'h00),
        .imem_req_valid  (req_valid2),
        .imem_req_ready  (req_ready2),
        .imem_req_addr   (req_addr2),
        .imem_resp_valid (resp_valid2),
        .imem_resp_data  (resp_data2),
`ifdef FETCH_PERF_EN
        .perf_fetched    (perf_fetched2),
        .perf_dropped    (perf_dropped2),
        .perf_stall      (perf_stall2),
`endif
        .instr_valid     (ivalid2),
        .instr_ready     (iready2),
        .instr_data      (idata2),
        .instr_pc        (ipc2)
    );

    // ------------------------------------------------------------------
    // Bookkeeping and reference model
    // ------------------------------------------------------------------
    int          checks   = 0;
    int          failures = 0;

    ent_t        m_q[$];        // entries the DUT queue must hold
    int          m_out;         // requests accepted, not answered
    int          m_drop;        // responses still to discard
    logic [31:0] m_fetch;
    logic [31:0] m_resp_pc;
    logic [31:0] pend[$];       // memory model: addresses awaiting response
    ent_t        got[$];        // what the consumer actually received
    int          accepts;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h8B150289 ^ (a * 32'h9E3779B1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_req_valid();
        return ((m_q.size() + m_out) < 4) && (m_out < 4);
    endfunction

    task automatic model_reset();
        m_q.delete();
        pend.delete();
        m_out     = 0;
        m_drop    = 0;
        m_fetch   = 32'h0;
        m_resp_pc = 32'h0;
        accepts   = 0;
    endtask

    task automatic compare();
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, m_req_valid()});
        if (m_req_valid()) check("req_addr", imem_req_addr, m_fetch);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, (m_q.size() > 0)});
        if (m_q.size() > 0) begin
            check("instr_pc", instr_pc, m_q[0].pc);
            check("instr_data", instr_data, m_q[0].data);
        end
    endtask

    // One clock cycle: compare, drive inputs at the falling edge, then
    // advance the model at the rising edge. Probabilities are percent.
    task automatic run_cycle(input bit rdr, input logic [31:0] rpc,
                             input int p_rdy, input int p_resp,
                             input int p_ird, input int p_err);
        bit acc, resp, pop;
        int new_out;
        @(negedge clock);
        compare();
        redirect_valid = rdr;
        redirect_pc    = rpc;
        imem_req_ready = ($urandom_range(99) < p_rdy);
        instr_ready    = ($urandom_range(99) < p_ird);
        if (pend.size() > 0) begin
            imem_resp_valid = ($urandom_range(99) < p_resp);
            imem_resp_data  = mem_word(pend[0]);
        end else begin
            imem_resp_valid = ($urandom_range(99) < p_err);
            imem_resp_data  = $urandom;
        end
        if (instr_valid && instr_ready) got.push_back('{instr_pc, instr_data});
        @(posedge clock);
        acc  = m_req_valid() && imem_req_ready;
        resp = imem_resp_valid && (m_out > 0);
        pop  = (m_q.size() > 0) && instr_ready;
        if (acc) begin
            pend.push_back(m_fetch);
            accepts++;
        end
        if (resp) void'(pend.pop_front());
        new_out = m_out + int'(acc) - int'(resp);
        if (pop) void'(m_q.pop_front());
        if (rdr) begin
            m_q.delete();
            m_fetch   = rpc;
            m_resp_pc = rpc;
            m_drop    = new_out;
        end else begin
            if (acc) m_fetch += 32'd4;
            if (resp) begin
                if (m_drop > 0) m_drop--;
                else begin
                    m_q.push_back('{m_resp_pc, imem_resp_data});
                    m_resp_pc += 32'd4;
                end
            end
        end
        m_out = new_out;
    endtask

    task automatic idle_inputs();
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        instr_ready     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        idle_inputs();
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr_data", instr_data, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        model_reset();
        got.delete();
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int   n;
        logic [31:0] pend2[$];
        logic [7:0]  got2[$];
        int   nresp2;
        bit   s_req2;
        logic [7:0] s_addr2;

        reset  = 1'b1;
        reset2 = 1'b1;
        idle_inputs();
        req_ready2  = 1'b0;
        resp_valid2 = 1'b0;
        resp_data2  = 32'h0;
        iready2     = 1'b0;
        model_reset();
        #1;
        check("init_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("init_instr_valid", {31'b0, instr_valid}, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Streaming at full rate
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 100, 100, 100, 0);
        for (int i = 0; i < 5; i++)
            check("stream_pc", (got.size() > i) ? got[i].pc : 32'hFFFF_FFFF, 32'(i * 4));
        check("stream_data0", (got.size() > 0) ? got[0].data : 32'h0, 32'h8B150289);
`ifdef FETCH_PERF_EN
        check("perf_stall_stream", perf_stall, 32'd2);
`endif

        // Back-pressure: only DEPTH requests may go out
        do_reset();
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 100, 100, 0, 0);
        #1;
        check("bp_accepts", 32'(accepts), 32'd4);
        check("bp_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("bp_addr", imem_req_addr, 32'h10);
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 32'h0, 100, 100, 100, 0);
        for (int i = 0; i < 8; i++)
            check("bp_pc", (got.size() > i) ? got[i].pc : 32'hFFFF_FFFF, 32'(i * 4));

        // Redirect with two requests in flight
        do_reset();
        run_cycle(1'b0, 32'h0, 100, 0, 0, 0);
        run_cycle(1'b0, 32'h0, 100, 0, 0, 0);
        check("redir_out", 32'(m_out), 32'd2);
        run_cycle(1'b1, 32'h100, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 32'h0, 100, 100, 100, 0);
        check("redir_first_pc", (got.size() > 0) ? got[0].pc : 32'hFFFF_FFFF, 32'h100);
        check("redir_second_pc", (got.size() > 1) ? got[1].pc : 32'hFFFF_FFFF, 32'h104);
`ifdef FETCH_PERF_EN
        check("perf_dropped_redir", perf_dropped, 32'd2);
        check("perf_fetched_redir", perf_fetched, 32'(got.size() + m_q.size()));
`endif

        // Redirect + response + accept + consume in one cycle
        do_reset();
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 32'h0, 100, 100, 100, 0);
        got.delete();
        run_cycle(1'b1, 32'h200, 100, 100, 100, 0);
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 100, 100, 100, 0);
        check("simul_consumed_pc", (got.size() > 0) ? got[0].pc : 32'hFFFF_FFFF, 32'hC);
        check("simul_next_pc", (got.size() > 1) ? got[1].pc : 32'hFFFF_FFFF, 32'h200);

        // Asynchronous reset while the queue holds three entries
        do_reset();
        n = 0;
        while (m_q.size() != 3 && n < 20) begin
            run_cycle(1'b0, 32'h0, 100, 100, 0, 0);
            n++;
        end
        check("fill_reached", 32'(m_q.size()), 32'd3);
        @(negedge clock);
        check("pre_rst_instr_valid", {31'b0, instr_valid}, 32'h1);
        #2 reset = 1'b1;
        idle_inputs();
        #1;
        check("async_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("async_req_valid", {31'b0, imem_req_valid}, 32'h0);
        model_reset();
        got.delete();
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("post_rst_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("post_rst_addr", imem_req_addr, 32'h0);

        // Randomised traffic with redirects and stray responses
        for (int i = 0; i < 3000; i++)
            run_cycle(($urandom_range(99) < 4), $urandom & 32'hFFFF_FFFC, 70, 60, 70, 5);

        // PC wrap on the 8-bit instance
        @(negedge clock);
        reset2 = 1'b0;
        nresp2 = 0;
        for (int i = 0; i < 40 && got2.size() < 4; i++) begin
            @(negedge clock);
            req_ready2 = 1'b1;
            iready2    = 1'b1;
            if (pend2.size() > 0 && nresp2 < 4) begin
                resp_valid2 = 1'b1;
                resp_data2  = pend2[0];
            end else begin
                resp_valid2 = 1'b0;
                resp_data2  = 32'h0;
            end
            if (ivalid2) got2.push_back(ipc2);
            s_req2  = req_valid2;
            s_addr2 = req_addr2;
            @(posedge clock);
            if (s_req2 && req_ready2) pend2.push_back({24'h0, s_addr2});
            if (resp_valid2) begin
                void'(pend2.pop_front());
                nresp2++;
            end
        end
        check("wrap_pc0", {24'h0, (got2.size() > 0) ? got2[0] : 8'h11}, 32'hF8);
        check("wrap_pc1", {24'h0, (got2.size() > 1) ? got2[1] : 8'h11}, 32'hFC);
        check("wrap_pc2", {24'h0, (got2.size() > 2) ? got2[2] : 8'h11}, 32'h00);
        check("wrap_pc3", {24'h0, (got2.size() > 3) ? got2[3] : 8'h11}, 32'h04);
        check("wrap_data3", idata2 & 32'h0, 32'h0);
`ifdef FETCH_PERF_EN
        check("wrap_perf_fetched", perf_fetched2, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
